// File: rtl/wb_gpio_debounce.sv
// wb_gpio_debounce -- Wishbone classic GPIO slave with per-channel debounce
// and edge-detect interrupts.
//
// Ports
//   wb_clk, wb_rstn        clock, asynchronous active-low reset
//   wb_adr_i[2:0]          word address (byte address bits 4:2)
//   wb_dat_i/wb_dat_o      write / read data (read data valid with ack)
//   wb_sel_i[3:0]          byte enables
//   wb_we_i, wb_cyc_i, wb_stb_i
//   wb_ack_o, wb_err_o     one-cycle acknowledge / error (address 7)
//   gpio_i                 raw asynchronous pad inputs
//   gpio_o, gpio_oe        pad output data and drive enable (1 = drive)
//   irq_o                  level interrupt, |(IRQ_STATUS & IRQ_EN), registered
//
// Register map (word offsets): 0 DATA_IN (RO), 1 DATA_OUT, 2 DIR, 3 IRQ_EN,
// 4 EDGE_POL (1 = rising), 5 IRQ_STATUS (W1C), 6 DEBOUNCE, 7 unmapped (err).

// Per-channel debouncer: stable follows sync once it has differed for
// i_dbmax consecutive cycles. o_chg flags the edge on which stable flips.
module wb_gpio_debounce_ch #(
    parameter int DB_W = 16
) (
    input  logic            wb_clk,
    input  logic            wb_rstn,
    input  logic            i_sync,
    input  logic [DB_W-1:0] i_dbmax,
    output logic            o_stable,
    output logic            o_chg
);
    logic [DB_W-1:0] r_cnt;
    logic            r_stable;
    logic [DB_W:0]   w_cnt_nx;
    logic            w_diff;

    assign w_diff   = i_sync ^ r_stable;
    // One bit wider so the compare is done before the counter could wrap.
    assign w_cnt_nx = {1'b0, r_cnt} + (DB_W+1)'(1);
    assign o_chg    = w_diff && (w_cnt_nx >= {1'b0, i_dbmax});
    assign o_stable = r_stable;

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_diff) begin
            r_cnt    <= '0;
        end else if (o_chg) begin
            r_stable <= i_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= w_cnt_nx[DB_W-1:0];
        end
    end
endmodule

module wb_gpio_debounce #(
    parameter int          NGPIO       = 8,
    parameter int          DB_W        = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned DB_RESET    = 16'd5000
) (
    input  logic             wb_clk,
    input  logic             wb_rstn,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    input  logic [NGPIO-1:0] gpio_i,
    output logic [NGPIO-1:0] gpio_o,
    output logic [NGPIO-1:0] gpio_oe,
    output logic             irq_o
);
    logic [NGPIO-1:0] r_dout, r_dir, r_ien, r_pol, r_sts;
    logic [DB_W-1:0]  r_db;
    logic             r_ack, r_err, r_irq;
    logic [31:0]      r_dat;
    logic [SYNC_STAGES-1:0][NGPIO-1:0] r_sync;

    logic             w_req, w_wr, w_unmapped, w_unused;
    logic [31:0]      w_bmask, w_rdat;
    logic [NGPIO-1:0] w_wmask, w_wdat, w_w1c;
    logic [NGPIO-1:0] w_sync, w_stable, w_chg, w_evt;
    logic [DB_W-1:0]  w_dbmax;

    // A new request is only accepted while no response is showing, which
    // makes a held strobe alternate ack / idle.
    assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_unmapped = (wb_adr_i == 3'd7);
    assign w_wr       = w_req & wb_we_i & ~w_unmapped;
    assign w_bmask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                         {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_wmask    = w_bmask[NGPIO-1:0];
    assign w_wdat     = wb_dat_i[NGPIO-1:0];
    assign w_w1c      = (w_wr && wb_adr_i == 3'd5) ? (w_wdat & w_wmask) : '0;
    assign w_unused   = ^{wb_dat_i, w_bmask};

    // DEBOUNCE = 0 behaves as 1.
    assign w_dbmax = (r_db == '0) ? DB_W'(1) : r_db;

    // Input synchroniser; sync[] is the last stage.
    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_i};
    end
    assign w_sync = r_sync[SYNC_STAGES-1];

    for (genvar g = 0; g < NGPIO; g++) begin : g_ch
        wb_gpio_debounce_ch #(.DB_W(DB_W)) u_ch (
            .wb_clk   (wb_clk),
            .wb_rstn  (wb_rstn),
            .i_sync   (w_sync[g]),
            .i_dbmax  (w_dbmax),
            .o_stable (w_stable[g]),
            .o_chg    (w_chg[g])
        );
    end

    // stable is about to take sync, so sync is the new level.
    assign w_evt = w_chg & ~(w_sync ^ r_pol);

    always_comb begin
        w_rdat = '0;
        case (wb_adr_i)
            3'd0:    w_rdat = 32'(w_stable);
            3'd1:    w_rdat = 32'(r_dout);
            3'd2:    w_rdat = 32'(r_dir);
            3'd3:    w_rdat = 32'(r_ien);
            3'd4:    w_rdat = 32'(r_pol);
            3'd5:    w_rdat = 32'(r_sts);
            3'd6:    w_rdat = 32'(r_db);
            default: w_rdat = '0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) begin
            r_dout <= '0;
            r_dir  <= '0;
            r_ien  <= '0;
            r_pol  <= '0;
            r_db   <= DB_W'(DB_RESET);
        end else if (w_wr) begin
            case (wb_adr_i)
                3'd1: r_dout <= (r_dout & ~w_wmask) | (w_wdat & w_wmask);
                3'd2: r_dir  <= (r_dir  & ~w_wmask) | (w_wdat & w_wmask);
                3'd3: r_ien  <= (r_ien  & ~w_wmask) | (w_wdat & w_wmask);
                3'd4: r_pol  <= (r_pol  & ~w_wmask) | (w_wdat & w_wmask);
                3'd6: r_db   <= (r_db & ~w_bmask[DB_W-1:0])
                              | (wb_dat_i[DB_W-1:0] & w_bmask[DB_W-1:0]);
                default: ;
            endcase
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) r_sts <= '0;
        else          r_sts <= (r_sts & ~w_w1c) | w_evt;
    end

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_req & ~w_unmapped;
            r_err <= w_req &  w_unmapped;
            r_dat <= w_req ? w_rdat : '0;
            r_irq <= |(r_sts & r_ien);
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;
    assign irq_o    = r_irq;
    assign gpio_o   = r_dout;
    assign gpio_oe  = r_dir;
endmodule

// File: tb/tb_wb_gpio_debounce.sv
module tb_wb_gpio_debounce;
    localparam int NG = 8;
    localparam int SY = 2;
    localparam logic [15:0] DBR = 16'd5000;

    logic          wb_clk = 1'b0;
    logic          wb_rstn = 1'b0;
    logic [2:0]    wb_adr_i = '0;
    logic [31:0]   wb_dat_i = '0;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_i = '0;
    logic          wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
    logic          wb_ack_o, wb_err_o, irq_o;
    logic [NG-1:0] gpio_i = '0;
    logic [NG-1:0] gpio_o, gpio_oe;

    wb_gpio_debounce #(.NGPIO(NG), .DB_W(16), .SYNC_STAGES(SY), .DB_RESET(DBR)) dut (
        .wb_clk(wb_clk), .wb_rstn(wb_rstn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .gpio_i(gpio_i),
        .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o));

    always #5 wb_clk = ~wb_clk;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Pad samples reach the debouncer after SY clock edges (a plain delay
    // queue); a channel flips once its synchronised level has disagreed
    // with the stable level for max(DEBOUNCE,1) consecutive edges, measured
    // as a span of edge numbers.
    logic [NG-1:0] m_dout, m_dir, m_ien, m_pol, m_sts, m_stable;
    logic [15:0]   m_db;
    logic          m_ack, m_err, m_irq;
    logic [31:0]   m_dat;
    logic [NG-1:0] m_pipe[$];
    bit            m_diff[NG];
    longint        m_start[NG];
    longint        m_edge;

    task automatic model_reset();
        m_dout = '0; m_dir = '0; m_ien = '0; m_pol = '0; m_sts = '0; m_stable = '0;
        m_db = DBR; m_ack = 0; m_err = 0; m_irq = 0; m_dat = '0; m_edge = 0;
        m_pipe.delete();
        for (int i = 0; i < SY; i++) m_pipe.push_back('0);
        for (int i = 0; i < NG; i++) begin m_diff[i] = 0; m_start[i] = 0; end
    endtask

    function automatic logic [31:0] bytemask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic model_step();
        logic req, nirq;
        logic [31:0] rd, msk;
        logic [NG-1:0] so, evt, wm, wd, w1c;
        longint lim;
        if (!wb_rstn) return;
        m_edge++;
        req = wb_cyc_i && wb_stb_i && !m_ack && !m_err;
        case (wb_adr_i)
            3'd0: rd = 32'(m_stable);
            3'd1: rd = 32'(m_dout);
            3'd2: rd = 32'(m_dir);
            3'd3: rd = 32'(m_ien);
            3'd4: rd = 32'(m_pol);
            3'd5: rd = 32'(m_sts);
            3'd6: rd = 32'(m_db);
            default: rd = 0;
        endcase
        so = m_pipe.pop_front();
        m_pipe.push_back(gpio_i);
        lim = (m_db == 0) ? 1 : longint'(m_db);
        evt = '0;
        for (int i = 0; i < NG; i++) begin
            if (so[i] != m_stable[i]) begin
                if (!m_diff[i]) begin m_diff[i] = 1; m_start[i] = m_edge; end
                if (m_edge - m_start[i] + 1 >= lim) begin
                    m_stable[i] = so[i];
                    m_diff[i] = 0;
                    evt[i] = (so[i] == m_pol[i]);
                end
            end else m_diff[i] = 0;
        end
        nirq = |(m_sts & m_ien);
        msk = bytemask(wb_sel_i);
        wm = msk[NG-1:0];
        wd = wb_dat_i[NG-1:0];
        w1c = '0;
        if (req && wb_we_i) begin
            case (wb_adr_i)
                3'd1: m_dout = (m_dout & ~wm) | (wd & wm);
                3'd2: m_dir  = (m_dir & ~wm) | (wd & wm);
                3'd3: m_ien  = (m_ien & ~wm) | (wd & wm);
                3'd4: m_pol  = (m_pol & ~wm) | (wd & wm);
                3'd5: w1c    = wd & wm;
                3'd6: m_db   = (m_db & ~msk[15:0]) | (wb_dat_i[15:0] & msk[15:0]);
                default: ;
            endcase
        end
        m_sts = (m_sts & ~w1c) | evt;
        m_irq = nirq;
        m_ack = req && (wb_adr_i != 3'd7);
        m_err = req && (wb_adr_i == 3'd7);
        m_dat = m_ack ? rd : 0;
    endtask

    task automatic chk_model();
        check("m_ack", wb_ack_o, m_ack);
        check("m_err", wb_err_o, m_err);
        if (m_ack) check("m_dat", wb_dat_o, m_dat);
        check("m_irq", irq_o, m_irq);
        check("m_gpio_o", gpio_o, m_dout);
        check("m_gpio_oe", gpio_oe, m_dir);
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic cyc1();
        @(posedge wb_clk);
        model_step();
        @(negedge wb_clk);
        chk_model();
    endtask

    task automatic bus(input logic [2:0] a, input logic we, input logic [3:0] sel,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic ack, output logic err);
        wb_adr_i = a; wb_we_i = we; wb_sel_i = sel; wb_dat_i = d;
        wb_cyc_i = 1; wb_stb_i = 1;
        ack = 0; err = 0; rd = 0;
        for (int n = 0; n < 4; n++) begin
            cyc1();
            if (wb_ack_o || wb_err_o) begin
                ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
                break;
            end
        end
        check("bus_resp", 32'(ack | err), 1);
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r; logic k, e;
        bus(a, 1'b0, 4'hF, 32'h0, r, k, e);
        check(name, r, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] r; logic k, e;
        bus(a, 1'b1, sel, d, r, k, e);
    endtask

    typedef struct {
        logic [2:0]  adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r; logic k, e;
        int lat;

        // ---- reset ----
        model_reset();
        repeat (3) @(negedge wb_clk);
        check("rst_ack", wb_ack_o, 0);
        check("rst_err", wb_err_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_oe", gpio_oe, 0);
        check("rst_o", gpio_o, 0);
        wb_rstn = 1;

        // ---- table-driven register access ----
        for (int a = 0; a < 8; a++)
            tbl.push_back('{3'(a), 1'b0, 4'hF, 32'h0, a != 7, a == 7,
                            (a == 6) ? 32'(DBR) : 32'h0});
        tbl.push_back('{3'd2, 1'b1, 4'b0001, 32'h0000_00FF, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd1, 1'b1, 4'b1111, 32'h0000_00A5, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd2, 1'b1, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd1, 1'b1, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd2, 1'b1, 4'b0010, 32'h0000_FF00, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd2, 1'b0, 4'hF,    32'h0,         1'b1, 1'b0, 32'h0000_00FF});
        tbl.push_back('{3'd1, 1'b0, 4'hF,    32'h0,         1'b1, 1'b0, 32'h0000_00A5});
        tbl.push_back('{3'd0, 1'b1, 4'hF,    32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd0, 1'b0, 4'hF,    32'h0,         1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd7, 1'b1, 4'hF,    32'h1234_5678, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{3'd6, 1'b1, 4'b0011, 32'hFFFF_0004, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd6, 1'b0, 4'hF,    32'h0,         1'b1, 1'b0, 32'h0000_0004});
        tbl.push_back('{3'd4, 1'b1, 4'hF,    32'hFFFF_FF01, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{3'd4, 1'b0, 4'hF,    32'h0,         1'b1, 1'b0, 32'h0000_0001});
        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dat, r, k, e);
            check($sformatf("tbl%0d_ack", i), k, tbl[i].exp_ack);
            check($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
            if (!tbl[i].we && tbl[i].exp_ack) check($sformatf("tbl%0d_rd", i), r, tbl[i].exp_rd);
        end
        check("oe_ff", gpio_oe, 8'hFF);
        check("o_a5", gpio_o, 8'hA5);

        // ---- 3-cycle glitch with DEBOUNCE=4 never reaches stable ----
        gpio_i[0] = 1;
        repeat (3) cyc1();
        gpio_i[0] = 0;
        repeat (10) cyc1();
        rd_chk("glitch_din", 3'd0, 0);
        rd_chk("glitch_sts", 3'd5, 0);

        // ---- held level: stable after 2+4 edges, irq one edge later ----
        wr(3'd3, 4'hF, 32'h1);
        gpio_i[0] = 1;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            cyc1();
            lat++;
            if (irq_o) break;
        end
        check("hold_irq_lat", lat, SY + 4 + 1);
        rd_chk("hold_din", 3'd0, 32'h1);
        wr(3'd5, 4'hF, 32'h1);
        wr(3'd3, 4'hF, 32'h2);
        wr(3'd4, 4'hF, 32'h4);
        rd_chk("clr_sts", 3'd5, 0);

        // ---- falling-edge interrupt on bit 1 ----
        gpio_i[1] = 1;
        repeat (10) cyc1();
        rd_chk("rise1_sts", 3'd5, 0);
        check("rise1_irq", irq_o, 0);
        gpio_i[1] = 0;
        repeat (6) cyc1();
        check("fall1_irq_pre", irq_o, 0);
        cyc1();
        check("fall1_irq", irq_o, 1);
        rd_chk("fall1_sts", 3'd5, 32'h2);
        wr(3'd5, 4'hF, 32'h2);
        check("w1c_irq_hold", irq_o, 1);
        cyc1();
        check("w1c_irq_drop", irq_o, 0);
        rd_chk("w1c_sts", 3'd5, 0);

        // ---- W1C coinciding with a new rising event on bit 2 ----
        gpio_i[2] = 1;
        repeat (10) cyc1();
        rd_chk("rise2_sts", 3'd5, 32'h4);
        gpio_i[2] = 0;
        repeat (10) cyc1();
        rd_chk("fall2_sts", 3'd5, 32'h4);
        gpio_i[2] = 1;
        repeat (5) cyc1();
        wr(3'd5, 4'hF, 32'h4);      // ack edge is the edge stable rises
        rd_chk("race_sts", 3'd5, 32'h4);
        wr(3'd5, 4'hF, 32'h4);
        rd_chk("race_clr", 3'd5, 0);

        // ---- asynchronous reset in the middle of a read ----
        wr(3'd2, 4'hF, 32'hFF);
        cyc1();
        wb_adr_i = 3'd2; wb_we_i = 0; wb_sel_i = 4'hF; wb_cyc_i = 1; wb_stb_i = 1;
        @(posedge wb_clk);
        model_step();
        #2;
        check("mid_ack_up", wb_ack_o, 1);
        wb_rstn = 0;
        #1;
        check("mid_ack_drop", wb_ack_o, 0);
        check("mid_oe", gpio_oe, 0);
        check("mid_o", gpio_o, 0);
        check("mid_irq", irq_o, 0);
        model_reset();
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge wb_clk);
        wb_rstn = 1;
        rd_chk("post_db", 3'd6, 32'(DBR));
        rd_chk("post_dir", 3'd2, 0);
        rd_chk("post_dout", 3'd1, 0);
        rd_chk("post_sts", 3'd5, 0);

        // ---- randomized traffic against the reference model ----
        wr(3'd6, 4'hF, 32'h2);
        for (int n = 0; n < 3000; n++) begin
            wb_cyc_i = ($urandom_range(0, 3) != 0);
            wb_stb_i = 1'($urandom_range(0, 1));
            wb_we_i  = 1'($urandom_range(0, 1));
            wb_adr_i = 3'($urandom_range(0, 7));
            wb_sel_i = 4'($urandom);
            wb_dat_i = $urandom;
            if (wb_adr_i == 3'd6) wb_dat_i = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ NG'(1 << $urandom_range(0, NG - 1));
            cyc1();
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        repeat (4) cyc1();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_gpio_debounce.md
Name: wb_gpio_debounce

Overview:
- Parametrised Wishbone classic slave GPIO controller; the next generation of the fixed LED/push-button wiring in the Cyclone10 SoC top level.
- Provides per-pin direction, output data, and input synchronisers.
- Adds programmable per-channel debounce and edge-detect interrupts.
- Sits on the SoC Wishbone bus and drives `user_led`, `user_pb` and `gpio` header pins through pad tristates instantiated outside the block.

Parameters:
- NGPIO, 8, number of channels (1..32).
- DB_W, 16, debounce counter width in bits.
- SYNC_STAGES, 2, input synchroniser flops (>=2).
- DB_RESET, 16'd5000, reset value of the DEBOUNCE register (truncated to DB_W).

Ports:
- wb_clk  in  1  bus/system clock; all logic synchronous to it.
- wb_rstn  in  1  asynchronous active-low reset.
- wb_adr_i  in  3  word address (byte address bits 4:2).
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o=1.
- wb_sel_i  in  4  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  error acknowledge for an unmapped address.
- gpio_i  in  NGPIO  raw pad inputs (asynchronous).
- gpio_o  out  NGPIO  output data to pads.
- gpio_oe  out  NGPIO  output enable, 1 = drive.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (wb_rstn=0, asynchronous) clears:
  - all synchroniser flops, stable[] and counters to 0;
  - DATA_OUT, DIR, IRQ_EN, EDGE_POL and IRQ_STATUS to 0;
  - wb_ack_o, wb_err_o, irq_o and wb_dat_o to 0.
  - DEBOUNCE is set to DB_RESET.
  - Consequence: gpio_oe=0 (all inputs), gpio_o=0.
- Register map (word offsets). Bits at and above NGPIO read 0 and ignore writes.
  - 0 DATA_IN, RO: debounced stable[].
  - 1 DATA_OUT, RW.
  - 2 DIR, RW.
  - 3 IRQ_EN, RW.
  - 4 EDGE_POL, RW: 1 = rising, 0 = falling.
  - 5 IRQ_STATUS, RW1C.
  - 6 DEBOUNCE, RW, bits DB_W-1:0.
  - 7 unmapped.
- Bus handshake:
  - When wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o, the block asserts ack (or err, for address 7) on the next edge for exactly one cycle.
  - Single-cycle latency; a held strobe yields ack every other cycle.
  - Writes take effect on the edge that raises ack, honouring wb_sel_i per byte.
  - Writes to DATA_IN and to address 7 are ignored.
  - Read data is registered alongside ack.
- gpio_o = DATA_OUT; gpio_oe = DIR; both registered, with no combinational path from the bus.
- Input path:
  - gpio_i passes through SYNC_STAGES flops to give sync[].
  - Debounce per channel:
    - If sync[i]==stable[i], cnt[i] clears to 0.
    - Otherwise cnt[i] increments.
    - When cnt[i]+1 >= max(DEBOUNCE,1), stable[i] takes sync[i] on that edge and cnt[i] clears.
    - Net effect: stable changes after max(DEBOUNCE,1) consecutive differing cycles. A glitch shorter than that never reaches stable. DEBOUNCE=0 behaves as 1.
  - Debounce and edge detection run regardless of DIR.
  - Counter saturates and cannot wrap: the compare happens before overflow.
  - A DEBOUNCE write mid-count applies from the next cycle and does not reset counters.
- Edges:
  - rise[i] = stable[i] changes 0->1; fall[i] = 1->0.
  - evt[i] = EDGE_POL[i] ? rise[i] : fall[i].
  - evt sets IRQ_STATUS[i] on the same edge on which stable changes, independent of IRQ_EN.
  - If evt[i] and a W1C of bit i happen in the same cycle, the set wins (status stays 1).
- irq_o is registered: irq_o <= |(IRQ_STATUS & IRQ_EN).
  - Latency is 1 cycle from the status update.
  - Clearing IRQ_EN drops irq_o on the next edge without clearing status.
- Latency from a pad change to DATA_IN = SYNC_STAGES + max(DEBOUNCE,1) cycles.
- Reset asserted mid-transaction: ack is dropped immediately and no partial write remains.

Test Plan:
- Reset, then read all 8 addresses:
  - addresses 0..5 return 0x00000000, address 6 returns DB_RESET, each with ack;
  - address 7 returns wb_err_o=1, wb_ack_o=0;
  - gpio_oe=0x00.
- Write DIR=0xFF with wb_sel_i=4'b0001, DATA_OUT=0x000000A5 -> gpio_oe=0xFF, gpio_o=0xA5. A write with wb_sel_i=0 leaves both unchanged.
- DEBOUNCE=4, pulse gpio_i[0] high for 3 cycles -> DATA_IN stays 0, IRQ_STATUS stays 0.
- DEBOUNCE=4, hold gpio_i[0] high -> DATA_IN[0]=1 exactly 2+4 cycles after the change.
- EDGE_POL[1]=0, IRQ_EN[1]=1, drive gpio_i[1] 1 then 0 (both debounced):
  - IRQ_STATUS=0x02 after the fall only;
  - irq_o=1 one cycle later;
  - write 0x02 to IRQ_STATUS -> status 0, irq_o=0 next cycle.
- A W1C on IRQ_STATUS in the same cycle as a new rising event on bit 2 with EDGE_POL[2]=1 -> bit 2 remains 1. An asynchronous wb_rstn pulse mid-read clears ack and all registers immediately.
